// File: rtl/final_phase_ctrl_if.sv
// Handshake and control bundle between the final packing FSM, its requester
// (start/flags/ack) and the packing datapath (mux selects, register loads).
interface final_phase_ctrl_if #(
    parameter int W_CNT = 16
);
    logic             start;
    logic             ovf_flag;
    logic             unf_flag;
    logic             ack;
    logic             sel_a;
    logic             sel_b;
    logic             ctrl_a;
    logic             ctrl_b;
    logic             busy;
    logic             ready;
    logic             ovf_o;
    logic             unf_o;
    logic [W_CNT-1:0] res_cnt;
    logic [W_CNT-1:0] exc_cnt;

    modport master (
        output start, ovf_flag, unf_flag, ack,
        input  sel_a, sel_b, ctrl_a, ctrl_b, busy, ready, ovf_o, unf_o,
        input  res_cnt, exc_cnt
    );

    modport slave (
        input  start, ovf_flag, unf_flag, ack,
        output sel_a, sel_b, ctrl_a, ctrl_b, busy, ready, ovf_o, unf_o,
        output res_cnt, exc_cnt
    );
endinterface

// File: rtl/final_phase_ctrl.sv
// Moore FSM sequencing the final IEEE-754 packing stage of the FP adder.
// Normal path: LOAD_RES -> LOAD_OUT -> DONE; exception path: EXC -> DONE.
// All outputs are registered and decoded from the next state, so they line
// up with the state they describe.
// Optional feature: define FINAL_PHASE_PERF_CNT_EN to build the saturating
// result/exception counters; otherwise res_cnt/exc_cnt are tied to 0.
module final_phase_ctrl #(
    parameter bit DONE_HOLD = 1'b1,
    parameter int W_CNT     = 16
) (
    input  logic               clk,
    input  logic               rst,
    final_phase_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_RES = 3'd1,
        LOAD_OUT = 3'd2,
        EXC      = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   ovf_lat_q, ovf_lat_d;
    logic   unf_lat_q, unf_lat_d;
    logic   accept;
    logic   exc_path;

    logic sel_a_q,  sel_a_d;
    logic sel_b_q,  sel_b_d;
    logic ctrl_a_q, ctrl_a_d;
    logic ctrl_b_q, ctrl_b_d;
    logic busy_q,   busy_d;
    logic ready_q,  ready_d;
    logic ovf_o_q,  ovf_o_d;
    logic unf_o_q,  unf_o_d;

    // Next state, flag latching and output decode of the next state
    always_comb begin
        state_d   = state_q;
        ovf_lat_d = ovf_lat_q;
        unf_lat_d = unf_lat_q;
        accept    = 1'b0;
        case (state_q)
            IDLE:     accept = bus.start;
            LOAD_RES: state_d = LOAD_OUT;
            LOAD_OUT: state_d = DONE;
            EXC:      state_d = DONE;
            DONE: begin
                // The exit cycle doubles as an accept slot for back-to-back ops
                if (!DONE_HOLD || bus.ack) begin
                    state_d = IDLE;
                    accept  = bus.start;
                end
            end
            default: begin
                state_d   = IDLE;
                ovf_lat_d = 1'b0;
                unf_lat_d = 1'b0;
            end
        endcase
        if (accept) begin
            // Overflow has priority: a simultaneous underflow is dropped
            ovf_lat_d = bus.ovf_flag;
            unf_lat_d = bus.unf_flag & ~bus.ovf_flag;
            state_d   = (bus.ovf_flag || bus.unf_flag) ? EXC : LOAD_RES;
        end

        exc_path = ovf_lat_d | unf_lat_d;
        ctrl_a_d = (state_d == LOAD_RES);
        ctrl_b_d = (state_d == LOAD_OUT) || (state_d == EXC);
        sel_b_d  = (state_d == LOAD_RES) || (state_d == LOAD_OUT) ||
                   ((state_d == DONE) && !exc_path);
        sel_a_d  = ((state_d == EXC) || (state_d == DONE)) && ovf_lat_d;
        ready_d  = (state_d == DONE);
        ovf_o_d  = (state_d == DONE) && ovf_lat_d;
        unf_o_d  = (state_d == DONE) && unf_lat_d;
        busy_d   = (state_d != IDLE);
    end

    // State, latched flags and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ovf_lat_q <= 1'b0;
            unf_lat_q <= 1'b0;
            sel_a_q   <= 1'b0;
            sel_b_q   <= 1'b0;
            ctrl_a_q  <= 1'b0;
            ctrl_b_q  <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            ovf_o_q   <= 1'b0;
            unf_o_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ovf_lat_q <= ovf_lat_d;
            unf_lat_q <= unf_lat_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            ctrl_a_q  <= ctrl_a_d;
            ctrl_b_q  <= ctrl_b_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            ovf_o_q   <= ovf_o_d;
            unf_o_q   <= unf_o_d;
        end
    end

    assign bus.sel_a  = sel_a_q;
    assign bus.sel_b  = sel_b_q;
    assign bus.ctrl_a = ctrl_a_q;
    assign bus.ctrl_b = ctrl_b_q;
    assign bus.busy   = busy_q;
    assign bus.ready  = ready_q;
    assign bus.ovf_o  = ovf_o_q;
    assign bus.unf_o  = unf_o_q;

`ifdef FINAL_PHASE_PERF_CNT_EN
    logic [W_CNT-1:0] res_cnt_q, res_cnt_d;
    logic [W_CNT-1:0] exc_cnt_q, exc_cnt_d;

    // Saturating completion counters, bumped on entry into DONE
    always_comb begin
        res_cnt_d = res_cnt_q;
        exc_cnt_d = exc_cnt_q;
        if ((state_q == LOAD_OUT) && (state_d == DONE) && !(&res_cnt_q))
            res_cnt_d = res_cnt_q + 1'b1;
        if ((state_q == EXC) && (state_d == DONE) && !(&exc_cnt_q))
            exc_cnt_d = exc_cnt_q + 1'b1;
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_cnt_q <= '0;
            exc_cnt_q <= '0;
        end else begin
            res_cnt_q <= res_cnt_d;
            exc_cnt_q <= exc_cnt_d;
        end
    end

    assign bus.res_cnt = res_cnt_q;
    assign bus.exc_cnt = exc_cnt_q;
`else
    assign bus.res_cnt = {W_CNT{1'b0}};
    assign bus.exc_cnt = {W_CNT{1'b0}};
`endif

endmodule

// File: tb/tb_final_phase_ctrl.sv
// Scoreboarded bench for final_phase_ctrl (DONE_HOLD=1). Inputs are driven
// and outputs sampled on the falling edge; the DUT works on the rising edge.
module tb_final_phase_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    final_phase_ctrl_if #(.W_CNT(16)) bus ();
    final_phase_ctrl #(.DONE_HOLD(1'b1), .W_CNT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef FINAL_PHASE_PERF_CNT_EN
    // Narrow-counter copy fed the same stimulus, for saturation
    final_phase_ctrl_if #(.W_CNT(2)) bus2 ();
    assign bus2.start    = bus.start;
    assign bus2.ovf_flag = bus.ovf_flag;
    assign bus2.unf_flag = bus.unf_flag;
    assign bus2.ack      = bus.ack;
    final_phase_ctrl #(.DONE_HOLD(1'b1), .W_CNT(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );
`endif

    typedef struct packed {
        logic ovf;
        logic unf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_res = 0;
    int   n_exc = 0;
    logic rdy_prev = 1'b0;

    // {sel_a, sel_b, ctrl_a, ctrl_b, busy, ready, ovf_o, unf_o}
    logic [7:0] outs;
    assign outs = {bus.sel_a, bus.sel_b, bus.ctrl_a, bus.ctrl_b,
                   bus.busy, bus.ready, bus.ovf_o, bus.unf_o};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: each op's status is checked on the first cycle of ready
    always @(negedge clk) begin
        if (bus.ready && !rdy_prev) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_ovf_o", {31'd0, bus.ovf_o}, {31'd0, mon_e.ovf});
                chk("sb_unf_o", {31'd0, bus.unf_o}, {31'd0, mon_e.unf});
                chk("sb_sel_a", {31'd0, bus.sel_a}, {31'd0, mon_e.ovf});
                chk("sb_sel_b", {31'd0, bus.sel_b}, {31'd0, ~(mon_e.ovf | mon_e.unf)});
            end
        end
        rdy_prev = bus.ready;
    end

    task automatic drive_start(input bit ovf, input bit unf);
        bus.start    = 1'b1;
        bus.ovf_flag = ovf;
        bus.unf_flag = unf;
        sb_q.push_back('{ovf: ovf, unf: unf & ~ovf});
    endtask

    // Walk an accepted op from cycle 1 to DONE; poke drives stray start/ack in LOAD_RES
    task automatic track(input bit ovf, input bit unf, input bit poke);
        @(negedge clk);
        bus.start = 1'b0; bus.ovf_flag = 1'b0; bus.unf_flag = 1'b0; bus.ack = 1'b0;
        if (!(ovf || unf)) begin
            chk("c1_load_res", {24'd0, outs}, {24'd0, 8'b0110_1000});
            if (poke) begin
                bus.start = 1'b1; bus.ovf_flag = 1'b1; bus.ack = 1'b1;
            end
            @(negedge clk);
            bus.start = 1'b0; bus.ovf_flag = 1'b0; bus.ack = 1'b0;
            chk("c2_load_out", {24'd0, outs}, {24'd0, 8'b0101_1000});
            n_res++;
        end else begin
            chk("c1_exc", {24'd0, outs}, {24'd0, ovf, 7'b001_1000});
            n_exc++;
        end
        @(negedge clk);
        chk("done", {24'd0, outs},
            {24'd0, ovf, ~(ovf | unf), 4'b0011, ovf, unf & ~ovf});
    endtask

    // Wait in DONE for hold cycles, then ack and expect IDLE
    task automatic finish_op(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("done_hold", {30'd0, bus.ready, bus.busy}, 32'd3);
        end
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        chk("idle_after_ack", {24'd0, outs}, 32'd0);
    endtask

    task automatic do_op(input bit ovf, input bit unf, input int hold);
        drive_start(ovf, unf);
        track(ovf, unf, 1'b0);
        finish_op(hold);
    endtask

    task automatic chk_counters(input string tag);
`ifdef FINAL_PHASE_PERF_CNT_EN
        chk({tag, "_res"}, {16'd0, bus.res_cnt}, n_res);
        chk({tag, "_exc"}, {16'd0, bus.exc_cnt}, n_exc);
        chk({tag, "_res_sat"}, {30'd0, bus2.res_cnt}, (n_res > 3) ? 3 : n_res);
        chk({tag, "_exc_sat"}, {30'd0, bus2.exc_cnt}, (n_exc > 3) ? 3 : n_exc);
`else
        chk({tag, "_res_off"}, {16'd0, bus.res_cnt}, 32'd0);
        chk({tag, "_exc_off"}, {16'd0, bus.exc_cnt}, 32'd0);
`endif
    endtask

    initial begin
        bus.start = 1'b0; bus.ovf_flag = 1'b0; bus.unf_flag = 1'b0; bus.ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {24'd0, outs}, 32'd0);
        chk_counters("reset_cnt");
        rst = 1'b1;

        // Idle without start, and a stray ack in IDLE, change nothing
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        @(negedge clk);
        chk("idle_no_start", {24'd0, outs}, 32'd0);

        // Normal path, ready at cycle 3, ack in cycle 5
        do_op(1'b0, 1'b0, 2);
        // Overflow, underflow, both flags
        do_op(1'b1, 1'b0, 0);
        do_op(1'b0, 1'b1, 1);
        do_op(1'b1, 1'b1, 0);

        // Back-to-back: ack+start in DONE, stray start/ack during LOAD_RES
        drive_start(1'b0, 1'b0);
        track(1'b0, 1'b0, 1'b0);
        bus.ack = 1'b1;
        drive_start(1'b0, 1'b0);
        track(1'b0, 1'b0, 1'b1);
        bus.ack = 1'b1;
        drive_start(1'b0, 1'b1);
        track(1'b0, 1'b1, 1'b0);
        finish_op(0);
        chk_counters("mid_cnt");

        // Asynchronous reset in LOAD_OUT aborts the op
        drive_start(1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("rst_c1", {24'd0, outs}, {24'd0, 8'b0110_1000});
        @(negedge clk);
        chk("rst_c2", {24'd0, outs}, {24'd0, 8'b0101_1000});
        #2 rst = 1'b0;
        #1 chk("async_rst_outs", {24'd0, outs}, 32'd0);
        sb_q.delete();
        n_res = 0;
        n_exc = 0;
        @(negedge clk);
        chk_counters("rst_cnt");
        rst = 1'b1;
        do_op(1'b0, 1'b0, 2);

        // Three normal (one already done) and two exception ops
        do_op(1'b0, 1'b0, 0);
        do_op(1'b0, 1'b0, 1);
        do_op(1'b1, 1'b0, 0);
        do_op(1'b0, 1'b1, 0);
        chk_counters("cnt_3_2");

        // Random flags and ack delays, enough normal ops to saturate W_CNT=2
        for (int k = 0; k < 12; k++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        do_op(1'b0, 1'b0, 0);
        do_op(1'b0, 1'b0, 0);
        chk_counters("final_cnt");

        @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
